multicycle_ctr: RTL
===================

Name: multicycle_ctr

Overview:
- Multicycle control FSM for the MIPS datapath. It sequences one shared ALU and one unified instruction/data memory across FETCH/DECODE/EXECUTE/MEM/WB states.
- It replaces the single-cycle combinational Ctr and drives all datapath mux selects, enables and ALUControl.
- It handles a variable-latency memory through a MemReq/MemReady handshake, keeps an instruction-retired counter, and flags illegal opcodes and memory stalls.

Parameters:
CNT_W, 32, width of InstrCount retired-instruction counter
MAX_WAIT, 16, memory wait cycles before MemErr sets (sticky); 0 disables check

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous, active-low reset
OpCode  input  6  instruction bits [31:26], taken from the instruction register
Funct  input  6  instruction bits [5:0]
Zero  input  1  ALU zero flag
MemReady  input  1  memory completes the current access this cycle
MemReq  output  1  memory access in progress
MemWrite  output  1  write strobe, valid with MemReq
IorD  output  1  0=PC addresses memory, 1=ALUOut addresses memory
IRWrite  output  1  load instruction register
RegDst  output  1  0=rt, 1=rd
MemtoReg  output  1  0=ALUOut, 1=memory data register
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0=PC, 1=register A
ALUSrcB  output  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
ALUControl  output  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
PCSrc  output  2  00=ALU result, 01=ALUOut, 10=jump target
PCEn  output  1  PC load enable = PCWrite | (Branch & Zero)
IllegalOp  output  1  one-cycle pulse in DECODE on an unknown opcode
MemErr  output  1  sticky; memory wait exceeded MAX_WAIT
InstrCount  output  CNT_W  instructions retired, wraps modulo 2^CNT_W
State  output  4  current state encoding, for debug

Behaviour:
- Reset (Rst=0, asynchronous):
  - State=FETCH, InstrCount=0, MemErr=0, wait counter=0.
  - All outputs are decoded from FETCH with MemReady masked: MemReq=1, every enable 0.
- After Rst deasserts, the first fetch starts on the next rising edge of Clk.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- FETCH:
  - Drives MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=add, PCSrc=00.
  - Stays in FETCH while MemReady=0.
  - In the cycle MemReady=1: IRWrite=1, PCWrite=1, then go to DECODE.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUControl=add to precompute the branch target.
  - Opcode dispatch:
    - 000000 (R-type) -> EXEC
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other opcode -> IllegalOp=1, InstrCount unchanged, go to FETCH
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: MemReq=1, IorD=1. Waits for MemReady, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Retires, then FETCH.
- MEMWR: MemReq=1, MemWrite=1, IorD=1. Waits for MemReady, then retires and goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00. ALUControl from Funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other Funct gives IllegalOp=1 and a return to FETCH with no writeback.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Retires, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, Branch=1. Retires, then FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add, then ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Retires, then FETCH.
- JUMP: PCSrc=10, PCWrite=1. Retires, then FETCH.
- Latency with MemReady tied to 1:
  - beq and j: 3 cycles.
  - R-type, sw, addi: 4 cycles.
  - lw: 5 cycles.
  - Each memory-wait cycle adds 1.
- "Retires" means InstrCount increments by 1 on the exit edge of the final state. It wraps from all-ones to 0.
- MemReady is ignored whenever MemReq=0.
- Any output not listed for a state is 0, including MemWrite, RegWrite, IRWrite and PCEn.
- Wait counter:
  - Counts consecutive MemReq=1 & MemReady=0 cycles and clears on a completed handshake.
  - Reaching MAX_WAIT sets MemErr. The FSM keeps waiting.
  - MemErr clears only on reset.
- Reset mid-instruction aborts the instruction: no retire, no further RegWrite/MemWrite, State returns to FETCH immediately.

Decomposition:
- Package mips_ctr_pkg holds:
  - state enum (4-bit);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - funct constants;
  - ALU encodings ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT;
  - ALUSrcB and PCSrc select constants.
- One sub-module, alu_decoder, maps (ALUOp[1:0], Funct) to ALUControl plus a funct_illegal flag.

Test Plan:
- MemReady=1; sequence R-type add, Funct=100000 -> FETCH,DECODE,EXEC,ALUWB in 4 cycles; RegWrite=1 and RegDst=1 only in ALUWB; InstrCount 0->1.
- lw with MemReady low for 3 cycles in FETCH and 2 in MEMRD -> IRWrite pulses once on the MemReady edge; total 10 cycles; MemWB RegWrite=1 with MemtoReg=1.
- beq with Zero=1, then Zero=0 -> PCEn=1 with PCSrc=01 in BRANCH for the first case only; each takes 3 cycles.
- OpCode=111111 -> IllegalOp single pulse in DECODE, back to FETCH next cycle, InstrCount unchanged; R-type with Funct=000001 gives the same response from EXEC.
- MAX_WAIT=16, MemReady held 0 in FETCH for 20 cycles -> MemErr rises after 16 wait cycles and stays 1 after MemReady returns; the instruction completes normally.
- Rst driven low asynchronously mid-MEMWR -> MemWrite drops before the next edge; State=FETCH, InstrCount=0, MemErr=0.

Source files
------------

// File: rtl/mips_ctr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctr_pkg
// Description : Shared types and encodings for the multicycle MIPS controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctr_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctr_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctr_if
// Description : Memory handshake between the controller and unified memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctr_if;
    logic MemReq;
    logic MemWrite;
    logic IorD;
    logic MemReady;

    modport master (output MemReq, output MemWrite, output IorD, input MemReady);
    modport slave  (input MemReq, input MemWrite, input IorD, output MemReady);
endinterface
`default_nettype wire

// File: rtl/multicycle_ctr_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps ALUOp and Funct to ALUControl; flags unsupported Funct.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import mips_ctr_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_control,
    output logic       o_funct_illegal
);

    always_comb begin
        o_alu_control   = ALU_ADD;
        o_funct_illegal = 1'b0;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alu_control = ALU_ADD;
                    FN_SUB:  o_alu_control = ALU_SUB;
                    FN_AND:  o_alu_control = ALU_AND;
                    FN_OR:   o_alu_control = ALU_OR;
                    FN_SLT:  o_alu_control = ALU_SLT;
                    default: begin
                        o_alu_control   = 4'b0000;
                        o_funct_illegal = 1'b1;
                    end
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctr.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctr
// Description : Multicycle MIPS control FSM with memory handshake, retire
//               counter and sticky memory-timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctr
    import mips_ctr_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [5:0]           OpCode,
    input  logic [5:0]           Funct,
    input  logic                 Zero,
    multicycle_ctr_if.master     mem,
    output logic                 IRWrite,
    output logic                 RegDst,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [3:0]           ALUControl,
    output logic [1:0]           PCSrc,
    output logic                 PCEn,
    output logic                 IllegalOp,
    output logic                 MemErr,
    output logic [CNT_W-1:0]     InstrCount,
    output logic [3:0]           State
);

    localparam int c_wait_w = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(MAX_WAIT);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      instr_count_q, instr_count_d;
    logic [c_wait_w-1:0]   wait_cnt_q, wait_cnt_d;
    logic                  mem_err_q, mem_err_d;

    logic       w_ready, w_stall, w_retire, w_pc_write, w_branch, w_alu_en;
    logic       w_mem_req, w_mem_write, w_iord, w_funct_illegal;
    logic [1:0] w_alu_op;
    logic [3:0] w_alu_ctl;

    // Ready is masked during reset so the FETCH decode cannot strobe enables
    assign w_ready = mem.MemReady & Rst;
    assign w_stall = w_mem_req & ~w_ready;

    alu_decoder u_alu_decoder (
        .i_alu_op        (w_alu_op),
        .i_funct         (Funct),
        .o_alu_control   (w_alu_ctl),
        .o_funct_illegal (w_funct_illegal)
    );

    always_comb begin
        state_d     = state_q;
        w_mem_req   = 1'b0;
        w_mem_write = 1'b0;
        w_iord      = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        w_alu_op    = ALUOP_ADD;
        w_alu_en    = 1'b0;
        PCSrc       = PCSRC_ALU;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        IllegalOp   = 1'b0;
        w_retire    = 1'b0;
        case (state_q)
            S_FETCH: begin
                w_mem_req = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                w_alu_en  = 1'b1;
                if (w_ready) begin
                    IRWrite    = 1'b1;
                    w_pc_write = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB  = SRCB_IMM_SH2;
                w_alu_en = 1'b1;
                case (OpCode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        IllegalOp = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_IMM;
                w_alu_en = 1'b1;
                state_d  = (OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                if (w_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                w_retire = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                if (w_ready) begin
                    w_retire = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXEC: begin
                ALUSrcA  = 1'b1;
                w_alu_op = ALUOP_FUNCT;
                w_alu_en = 1'b1;
                if (w_funct_illegal) begin
                    IllegalOp = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_ALUWB;
                end
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                w_retire = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                w_alu_op = ALUOP_SUB;
                w_alu_en = 1'b1;
                PCSrc    = PCSRC_ALUOUT;
                w_branch = 1'b1;
                w_retire = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_IMM;
                w_alu_en = 1'b1;
                state_d  = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                w_retire = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCSrc      = PCSRC_JUMP;
                w_pc_write = 1'b1;
                w_retire   = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        instr_count_d = instr_count_q;
        wait_cnt_d    = wait_cnt_q;
        mem_err_d     = mem_err_q;
        if (w_retire) instr_count_d = instr_count_q + CNT_W'(1);
        // Wait counter saturates at the limit; the FSM keeps waiting
        if (w_mem_req && w_ready) begin
            wait_cnt_d = '0;
        end else if (w_stall && (wait_cnt_q != c_wait_max)) begin
            wait_cnt_d = wait_cnt_q + c_wait_w'(1);
        end
        if ((MAX_WAIT != 0) && w_stall && (wait_cnt_d == c_wait_max)) mem_err_d = 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q       <= S_FETCH;
            instr_count_q <= '0;
            wait_cnt_q    <= '0;
            mem_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_err_q     <= mem_err_d;
        end
    end

    assign mem.MemReq   = w_mem_req;
    assign mem.MemWrite = w_mem_write;
    assign mem.IorD     = w_iord;
    assign ALUControl   = w_alu_en ? w_alu_ctl : 4'b0000;
    assign PCEn         = w_pc_write | (w_branch & Zero);
    assign MemErr       = mem_err_q;
    assign InstrCount   = instr_count_q;
    assign State        = state_q;

endmodule
`default_nettype wire
